// File: rtl/icache_fill_ctrl.sv
// Direct-mapped, read-only instruction cache with a streaming block-refill FSM.
// Hits return the word in the same cycle; a miss stalls fetch while the block streams in.
module icache_fill_ctrl #(
  parameter int NUM_SETS        = 32,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  output logic [15:0] cpu_data,
  output logic        stall,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_valid
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int TW = 15 - OW - IW;
  localparam logic [OW:0] CNT_FULL = (OW+1)'(WORDS_PER_BLOCK);
  localparam logic [OW:0] CNT_LAST = (OW+1)'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] missTag_q, missTag_d;
  logic [IW-1:0] missIndex_q, missIndex_d;
  logic [OW:0]   issueCnt_q, issueCnt_d;
  logic [OW:0]   recvCnt_q, recvCnt_d;

  logic [NUM_SETS-1:0] valid_q;
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [15:0]         data_q [NUM_SETS][WORDS_PER_BLOCK];

  logic [OW-1:0] reqOffset;
  logic [IW-1:0] reqIndex;
  logic [TW-1:0] reqTag;
  logic          hit;
  logic          fillWe;
  logic          lineCommit;
  logic          unusedAddrBit;

  assign reqOffset     = cpu_addr[OW:1];
  assign reqIndex      = cpu_addr[OW+IW:OW+1];
  assign reqTag        = cpu_addr[15:OW+IW+1];
  assign unusedAddrBit = cpu_addr[0];

  assign hit      = cpu_rd & valid_q[reqIndex] & (tag_q[reqIndex] == reqTag);
  assign cpu_data = hit ? data_q[reqIndex][reqOffset] : 16'h0000;

  always_comb begin
    state_d     = state_q;
    missTag_d   = missTag_q;
    missIndex_d = missIndex_q;
    issueCnt_d  = issueCnt_q;
    recvCnt_d   = recvCnt_q;
    stall       = 1'b1;
    mem_rd      = 1'b0;
    mem_addr    = 16'h0000;
    fillWe      = 1'b0;
    lineCommit  = 1'b0;
    case (state_q)
      IDLE: begin
        stall = cpu_rd & ~hit;
        if (cpu_rd && !hit) begin
          missTag_d   = reqTag;
          missIndex_d = reqIndex;
          issueCnt_d  = '0;
          recvCnt_d   = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        // Requests go out back to back while returns are absorbed in issue order.
        if (issueCnt_q < CNT_FULL) begin
          mem_rd     = 1'b1;
          mem_addr   = {missTag_q, missIndex_q, issueCnt_q[OW-1:0], 1'b0};
          issueCnt_d = issueCnt_q + 1'b1;
        end
        if (mem_valid) begin
          fillWe    = 1'b1;
          recvCnt_d = recvCnt_q + 1'b1;
          if (recvCnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE: begin
        lineCommit = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      missTag_q   <= '0;
      missIndex_q <= '0;
      issueCnt_q  <= '0;
      recvCnt_q   <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      missTag_q   <= missTag_d;
      missIndex_q <= missIndex_d;
      issueCnt_q  <= issueCnt_d;
      recvCnt_q   <= recvCnt_d;
      if (lineCommit) valid_q[missIndex_q] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone gate every hit.
  always_ff @(posedge clk) begin
    if (!rst && lineCommit) tag_q[missIndex_q] <= missTag_q;
    if (!rst && fillWe) data_q[missIndex_q][recvCnt_q[OW-1:0]] <= mem_data;
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: a fixed-latency memory model plus a
// set-level cache model predict hits, refill requests, stall length and returned data.
module tb_icache_fill_ctrl;

  localparam int WPB = 8;

  logic        clk = 1'b0;
  logic        rst, cpu_rd, stall, mem_rd, mem_valid;
  logic [15:0] cpu_addr, cpu_data, mem_addr, mem_data;

  always #5 clk = ~clk;

  icache_fill_ctrl #(.NUM_SETS(32), .WORDS_PER_BLOCK(WPB)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
    .cpu_data(cpu_data), .stall(stall), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_valid(mem_valid)
  );

  typedef struct {logic [15:0] addr; int due;} pend_t;

  int          nChecks = 0, nPass = 0, nFail = 0;
  int          cyc = 0, memLatency = 4, retCount = 0, strayCycles = 0;
  pend_t       pendQ[$];
  logic [15:0] reqLog[$];
  int          reqCycLog[$];
  logic        sStall, sMemRd;
  logic [15:0] sData, sMemAddr;
  bit          mValid[32];
  logic [6:0]  mTag[32];

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return 16'hA000 + {1'b0, a[15:1]};
  endfunction

  function automatic bit modelHit(input logic [15:0] a);
    return mValid[a[8:4]] && (mTag[a[8:4]] == a[15:9]);
  endfunction

  task automatic modelFill(input logic [15:0] a, inout logic [15:0] expReqs[$]);
    for (int w = 0; w < WPB; w++) expReqs.push_back({a[15:4], 3'(w), 1'b0});
    mValid[a[8:4]] = 1'b1;
    mTag[a[8:4]]   = a[15:9];
  endtask

  task automatic modelReset();
    for (int s = 0; s < 32; s++) mValid[s] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, log requests, then drive the memory return.
  task automatic cycleStep();
    pend_t p;
    @(negedge clk);
    sStall = stall; sData = cpu_data; sMemRd = mem_rd; sMemAddr = mem_addr;
    if (mem_rd) begin
      p.addr = mem_addr;
      p.due  = cyc + memLatency;
      pendQ.push_back(p);
      reqLog.push_back(mem_addr);
      reqCycLog.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    mem_valid = 1'b0;
    mem_data  = 16'h0000;
    if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
      mem_valid = 1'b1;
      mem_data  = memWord(pendQ[0].addr);
      void'(pendQ.pop_front());
      retCount++;
    end else if (strayCycles > 0) begin
      mem_valid = 1'b1;
      mem_data  = 16'hDEAD;
      strayCycles--;
    end
  endtask

  // Present a fetch and hold it until served; optionally retarget the PC mid-refill.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] altAddr,
                               input int switchAt, input string tag);
    logic [15:0] expReqs[$];
    logic [15:0] finalAddr;
    int misses = 0, stalls = 0, bad = 0, n;
    bit done = 1'b0;
    if (!modelHit(addr)) begin misses++; modelFill(addr, expReqs); end
    finalAddr = addr;
    if (switchAt > 0) begin
      finalAddr = altAddr;
      if (!modelHit(altAddr)) begin misses++; modelFill(altAddr, expReqs); end
    end
    reqLog.delete();
    reqCycLog.delete();
    cpu_rd   = 1'b1;
    cpu_addr = addr;
    for (int i = 0; i < 200 && !done; i++) begin
      cycleStep();
      if (!sStall) done = 1'b1;
      else begin
        stalls++;
        if (stalls == switchAt) cpu_addr = altAddr;
      end
    end
    checkOutput({tag, ".served"}, 32'(done), 32'd1);
    // Each miss costs its detect cycle plus WPB+L+1 refill cycles.
    checkOutput({tag, ".stallCycles"}, stalls, misses * (WPB + memLatency + 2));
    checkOutput({tag, ".reqCount"}, reqLog.size(), expReqs.size());
    n = (reqLog.size() < expReqs.size()) ? reqLog.size() : expReqs.size();
    for (int i = 0; i < n; i++) if (reqLog[i] !== expReqs[i]) bad++;
    checkOutput({tag, ".reqAddrBad"}, bad, 0);
    if (reqCycLog.size() >= WPB)
      checkOutput({tag, ".burst"}, reqCycLog[WPB-1] - reqCycLog[0], WPB - 1);
    checkOutput({tag, ".data"}, sData, memWord(finalAddr));
    checkOutput({tag, ".memRdIdle"}, sMemRd, 1'b0);
  endtask

  initial begin
    int start, bad;
    logic [15:0] a;
    rst = 1'b1; cpu_rd = 1'b0; cpu_addr = 16'h0000; mem_valid = 1'b0; mem_data = 16'h0000;
    modelReset();
    repeat (3) cycleStep();
    rst = 1'b0;
    cycleStep();
    checkOutput("reset.stall", sStall, 1'b0);
    checkOutput("reset.memRd", sMemRd, 1'b0);
    checkOutput("reset.memAddr", sMemAddr, 16'h0000);
    checkOutput("reset.cpuData", sData, 16'h0000);

    memLatency = 4;
    applyStimulus(16'h0000, 16'h0000, 0, "cold");
    for (int k = 1; k < WPB; k++) applyStimulus(16'(2 * k), 16'h0000, 0, "spatial");

    applyStimulus(16'h0200, 16'h0000, 0, "conflictNew");
    applyStimulus(16'h0000, 16'h0000, 0, "conflictBack");

    applyStimulus(16'h0010, 16'h0030, 3, "midFillSwitch");

    cpu_rd = 1'b0;
    strayCycles = 3;
    bad = 0;
    repeat (5) begin
      cycleStep();
      if (sStall || sMemRd || sData != 16'h0000) bad++;
    end
    checkOutput("stray.idleBad", bad, 0);
    applyStimulus(16'h0006, 16'h0000, 0, "stray.hitAfter");

    cpu_rd = 1'b1; cpu_addr = 16'h0040;
    start = retCount;
    for (int i = 0; i < 100 && (retCount - start) < 3; i++) cycleStep();
    checkOutput("rstMid.got3", retCount - start, 3);
    rst = 1'b1; cpu_rd = 1'b0;
    cycleStep();
    rst = 1'b0;
    modelReset();
    cycleStep();
    checkOutput("rstMid.memRd", sMemRd, 1'b0);
    checkOutput("rstMid.memAddr", sMemAddr, 16'h0000);
    checkOutput("rstMid.stall", sStall, 1'b0);
    checkOutput("rstMid.cpuData", sData, 16'h0000);
    bad = 0;
    repeat (10) begin
      cycleStep();
      if (sStall || sMemRd) bad++;
    end
    checkOutput("rstMid.lateBad", bad, 0);
    checkOutput("rstMid.drained", pendQ.size(), 0);
    applyStimulus(16'h0040, 16'h0000, 0, "rstMid.refetch");
    applyStimulus(16'h0002, 16'h0000, 0, "rstMid.invalidated");

    for (int i = 0; i < 30; i++) begin
      memLatency = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) begin
        cpu_rd = 1'b0;
        cpu_addr = 16'($urandom);
        cycleStep();
        checkOutput("rand.idleStall", sStall, 1'b0);
        checkOutput("rand.idleData", sData, 16'h0000);
      end
      a = {7'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0};
      applyStimulus(a, 16'h0000, 0, "rand");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
